// File: rtl/turnstile_bank_controller.sv
// turnstile_bank_controller
// A bank of turnstile lanes that share one coin validator. Each lane has a
// small lock FSM. A round-robin arbiter hands the validator to PENDING lanes
// one at a time. A shared counter tracks passages through the bank.
//
// Validator handshake: o_Val_Req rises together with a registered o_Val_Lane.
// Both then hold steady until i_Val_Done is sampled high, and i_Val_Ok is read
// in that same cycle. After that the request drops for at least one cycle
// before the next grant. i_Val_Done seen while no request is outstanding is
// ignored.
module turnstile_bank_controller #(
    parameter int NUM_LANES      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int COUNT_WIDTH    = 16,
    localparam int LANE_W        = $clog2(NUM_LANES)
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic [NUM_LANES-1:0]   i_Coin,
    input  logic [NUM_LANES-1:0]   i_Push,
    output logic                   o_Val_Req,
    output logic [LANE_W-1:0]      o_Val_Lane,
    input  logic                   i_Val_Done,
    input  logic                   i_Val_Ok,
    output logic [NUM_LANES-1:0]   o_Locked,
    output logic [NUM_LANES-1:0]   o_Reject,
    output logic [COUNT_WIDTH-1:0] o_Pass_Count
);

    // The timeout counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        LANE_LOCKED   = 2'd0,
        LANE_PENDING  = 2'd1,
        LANE_UNLOCKED = 2'd2
    } lane_state_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Lane state
    lane_state_t             r_lane_state [NUM_LANES];
    lane_state_t             w_lane_next  [NUM_LANES];
    logic [TMO_W-1:0]        r_tmo        [NUM_LANES];
    logic [TMO_W-1:0]        w_tmo_next   [NUM_LANES];
    logic [NUM_LANES-1:0]    r_coin_prev;
    logic [NUM_LANES-1:0]    w_coin_edge;
    logic [NUM_LANES-1:0]    w_done_lane;
    logic [NUM_LANES-1:0]    w_reject;
    logic [NUM_LANES-1:0]    w_pass;
    logic [NUM_LANES-1:0]    r_locked;
    logic [NUM_LANES-1:0]    r_reject;
    logic [COUNT_WIDTH-1:0]  w_pass_sum;
    logic [COUNT_WIDTH-1:0]  r_pass_count;

    // Arbiter state
    arb_state_t              r_arb_state;
    arb_state_t              w_arb_next;
    logic [LANE_W-1:0]       r_ptr;
    logic [LANE_W-1:0]       w_ptr_next;
    logic [LANE_W-1:0]       r_val_lane;
    logic [LANE_W-1:0]       w_val_lane_next;
    logic                    r_val_req;
    logic                    w_val_req_next;
    logic                    w_found;
    logic [LANE_W-1:0]       w_pick;
    logic [LANE_W-1:0]       w_cand;
    logic                    w_done;

    // The previous copy resets to 0, so a coin held high through reset still counts once.
    assign w_coin_edge = i_Coin & ~r_coin_prev;

    // Done only means something while a grant is outstanding.
    assign w_done = (r_arb_state == ARB_BUSY) && i_Val_Done;

    // Route the validator result to the granted lane only.
    always_comb begin
        w_done_lane = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_done_lane[l] = w_done && (r_val_lane == LANE_W'(l));
        end
    end

    // Lane next-state logic, timeout counters, reject and pass events.
    always_comb begin
        w_reject = '0;
        w_pass   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_lane_next[l] = r_lane_state[l];
            w_tmo_next[l]  = r_tmo[l];
            case (r_lane_state[l])
                LANE_LOCKED: begin
                    if (w_coin_edge[l]) begin
                        w_lane_next[l] = LANE_PENDING;
                    end
                end
                LANE_PENDING: begin
                    if (w_done_lane[l]) begin
                        if (i_Val_Ok) begin
                            w_lane_next[l] = LANE_UNLOCKED;
                            w_tmo_next[l]  = '0;
                        end else begin
                            w_lane_next[l] = LANE_LOCKED;
                            w_reject[l]    = 1'b1;
                        end
                    end
                end
                LANE_UNLOCKED: begin
                    // When a push and the timeout land on the same cycle, the push wins.
                    if (i_Push[l]) begin
                        w_lane_next[l] = LANE_LOCKED;
                        w_tmo_next[l]  = '0;
                        w_pass[l]      = 1'b1;
                    end else if (r_tmo[l] == TMO_LAST) begin
                        w_lane_next[l] = LANE_LOCKED;
                        w_tmo_next[l]  = '0;
                    end else begin
                        w_tmo_next[l]  = r_tmo[l] + TMO_W'(1);
                    end
                end
                default: begin
                    w_lane_next[l] = LANE_LOCKED;
                    w_tmo_next[l]  = '0;
                end
            endcase
        end
    end

    // Add up every lane that passed this cycle.
    always_comb begin
        w_pass_sum = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_pass_sum = w_pass_sum + COUNT_WIDTH'(w_pass[l]);
        end
    end

    // Lane registers, coin edge history, registered outputs and passage count.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_lane_state[l] <= LANE_LOCKED;
                r_tmo[l]        <= '0;
            end
            r_coin_prev  <= '0;
            r_locked     <= '1;
            r_reject     <= '0;
            r_pass_count <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_lane_state[l] <= w_lane_next[l];
                r_tmo[l]        <= w_tmo_next[l];
                r_locked[l]     <= (w_lane_next[l] != LANE_UNLOCKED);
            end
            r_coin_prev  <= i_Coin;
            r_reject     <= w_reject;
            r_pass_count <= r_pass_count + w_pass_sum;
        end
    end

    // Arbiter next-state logic: scan from the rotating pointer for the first PENDING lane.
    always_comb begin
        w_arb_next      = r_arb_state;
        w_ptr_next      = r_ptr;
        w_val_lane_next = r_val_lane;
        w_val_req_next  = r_val_req;
        w_found         = 1'b0;
        w_pick          = '0;
        w_cand          = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_cand = LANE_W'((int'(r_ptr) + k) % NUM_LANES);
            if (!w_found && (r_lane_state[w_cand] == LANE_PENDING)) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
        case (r_arb_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_arb_next      = ARB_BUSY;
                    w_val_lane_next = w_pick;
                    w_val_req_next  = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (i_Val_Done) begin
                    w_arb_next     = ARB_IDLE;
                    w_val_req_next = 1'b0;
                    w_ptr_next     = (r_val_lane == LANE_LAST) ? '0 : r_val_lane + LANE_W'(1);
                end
            end
            default: begin
                w_arb_next     = ARB_IDLE;
                w_val_req_next = 1'b0;
            end
        endcase
    end

    // Arbiter registers; reset abandons any validation in flight.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_arb_state <= ARB_IDLE;
            r_ptr       <= '0;
            r_val_lane  <= '0;
            r_val_req   <= 1'b0;
        end else begin
            r_arb_state <= w_arb_next;
            r_ptr       <= w_ptr_next;
            r_val_lane  <= w_val_lane_next;
            r_val_req   <= w_val_req_next;
        end
    end

    assign o_Val_Req    = r_val_req;
    assign o_Val_Lane   = r_val_lane;
    assign o_Locked     = r_locked;
    assign o_Reject     = r_reject;
    assign o_Pass_Count = r_pass_count;

endmodule

// File: tb/tb_turnstile_bank_controller.sv
// Directed bench for turnstile_bank_controller: NUM_LANES=4, TIMEOUT_CYCLES=8.
// Inputs change and outputs are checked on the falling edge of the clock.
module tb_turnstile_bank_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  coin;
    logic [3:0]  push;
    logic        val_done;
    logic        val_ok;
    logic        val_req;
    logic [1:0]  val_lane;
    logic [3:0]  locked;
    logic [3:0]  reject;
    logic [15:0] pass_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cnt;

    turnstile_bank_controller #(
        .NUM_LANES      (4),
        .TIMEOUT_CYCLES (8),
        .COUNT_WIDTH    (16)
    ) dut (
        .i_Clk        (clk),
        .i_Reset_n    (rst_n),
        .i_Coin       (coin),
        .i_Push       (push),
        .o_Val_Req    (val_req),
        .o_Val_Lane   (val_lane),
        .i_Val_Done   (val_done),
        .i_Val_Ok     (val_ok),
        .o_Locked     (locked),
        .o_Reject     (reject),
        .o_Pass_Count (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pulse reset for one cycle from a falling edge; the pass count expectation clears.
    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    // Coin on one or more lanes for one cycle; the grant appears one cycle after the coin is removed.
    task automatic drop_coin(input logic [3:0] lanes);
        coin = lanes;
        tick(1);
        coin = 4'b0000;
        tick(1);
    endtask

    // One validator result pulse.
    task automatic pulse_done(input logic ok);
        val_done = 1'b1;
        val_ok   = ok;
        tick(1);
        val_done = 1'b0;
        val_ok   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        coin     = '0;
        push     = '0;
        val_done = 1'b0;
        val_ok   = 1'b0;
        exp_cnt  = '0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            coin     = 4'($urandom_range(0, 15));
            push     = 4'($urandom_range(0, 15));
            val_done = 1'($urandom_range(0, 1));
            val_ok   = 1'($urandom_range(0, 1));
            tick(1);
            chk("rst_locked", 32'(locked), 32'hF);
            chk("rst_req", 32'(val_req), 32'h0);
            chk("rst_cnt", 32'(pass_cnt), 32'h0);
        end
        chk("rst_lane", 32'(val_lane), 32'h0);
        chk("rst_reject", 32'(reject), 32'h0);
        coin     = '0;
        push     = '0;
        val_done = 1'b0;
        val_ok   = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_locked", 32'(locked), 32'hF);
            chk("idle_req", 32'(val_req), 32'h0);
            chk("idle_cnt", 32'(pass_cnt), 32'h0);
        end

        // Accept and pass on lane 2
        coin = 4'b0100;
        tick(1);
        coin = 4'b0000;
        chk("acc_req_early", 32'(val_req), 32'h0);
        tick(1);
        chk("acc_req", 32'(val_req), 32'h1);
        chk("acc_lane", 32'(val_lane), 32'h2);
        pulse_done(1'b1);
        chk("acc_locked", 32'(locked), 32'hB);
        chk("acc_req_drop", 32'(val_req), 32'h0);
        chk("acc_no_reject", 32'(reject), 32'h0);
        push = 4'b0100;
        tick(1);
        push = 4'b0000;
        exp_cnt = exp_cnt + 16'd1;
        chk("pass_locked", 32'(locked), 32'hF);
        chk("pass_cnt", 32'(pass_cnt), 32'(exp_cnt));

        // Reject on lane 1 (pointer is 3, scan 3,0,1)
        drop_coin(4'b0010);
        chk("rej_req", 32'(val_req), 32'h1);
        chk("rej_lane", 32'(val_lane), 32'h1);
        pulse_done(1'b0);
        chk("rej_pulse", 32'(reject), 32'h2);
        chk("rej_locked", 32'(locked), 32'hF);
        chk("rej_cnt", 32'(pass_cnt), 32'(exp_cnt));
        tick(1);
        chk("rej_pulse_end", 32'(reject), 32'h0);

        // Round robin from a fresh pointer: lanes 0,1,3 then 0,1
        do_reset();
        tick(1);
        drop_coin(4'b1011);
        chk("rr_req0", 32'(val_req), 32'h1);
        chk("rr_lane0", 32'(val_lane), 32'h0);
        pulse_done(1'b0);
        chk("rr_gap", 32'(val_req), 32'h0);
        tick(1);
        chk("rr_lane1", 32'(val_lane), 32'h1);
        chk("rr_req1", 32'(val_req), 32'h1);
        pulse_done(1'b0);
        tick(1);
        chk("rr_lane3", 32'(val_lane), 32'h3);
        chk("rr_req3", 32'(val_req), 32'h1);
        pulse_done(1'b0);
        drop_coin(4'b0011);
        chk("rr2_req0", 32'(val_req), 32'h1);
        chk("rr2_lane0", 32'(val_lane), 32'h0);
        pulse_done(1'b0);
        tick(1);
        chk("rr2_lane1", 32'(val_lane), 32'h1);
        chk("rr2_req1", 32'(val_req), 32'h1);
        pulse_done(1'b0);
        chk("rr_cnt", 32'(pass_cnt), 32'(exp_cnt));

        // Timeout on lane 0: unlocked for exactly 8 cycles
        drop_coin(4'b0001);
        chk("tmo_lane", 32'(val_lane), 32'h0);
        pulse_done(1'b1);
        chk("tmo_unlocked_0", 32'(locked), 32'hE);
        for (int i = 1; i < 8; i++) begin
            tick(1);
            chk("tmo_unlocked", 32'(locked), 32'hE);
        end
        tick(1);
        chk("tmo_relocked", 32'(locked), 32'hF);
        chk("tmo_cnt", 32'(pass_cnt), 32'(exp_cnt));

        // Push on the expiry cycle still counts
        drop_coin(4'b0001);
        chk("col_lane", 32'(val_lane), 32'h0);
        pulse_done(1'b1);
        tick(7);
        chk("col_still_open", 32'(locked), 32'hE);
        push = 4'b0001;
        tick(1);
        push = 4'b0000;
        exp_cnt = exp_cnt + 16'd1;
        chk("col_locked", 32'(locked), 32'hF);
        chk("col_cnt", 32'(pass_cnt), 32'(exp_cnt));

        // Coin while lane 0 is unlocked raises no request
        drop_coin(4'b0001);
        pulse_done(1'b1);
        chk("unl_open", 32'(locked), 32'hE);
        drop_coin(4'b0001);
        tick(1);
        chk("unl_no_req", 32'(val_req), 32'h0);
        chk("unl_still_open", 32'(locked), 32'hE);
        push = 4'b0001;
        tick(1);
        push = 4'b0000;
        exp_cnt = exp_cnt + 16'd1;
        chk("unl_cnt", 32'(pass_cnt), 32'(exp_cnt));
        tick(1);
        chk("unl_no_req_after", 32'(val_req), 32'h0);

        // Two lanes pushing together add two (pointer 1: grant 1, then 0)
        drop_coin(4'b0011);
        chk("dual_lane1", 32'(val_lane), 32'h1);
        pulse_done(1'b1);
        chk("dual_open1", 32'(locked), 32'hD);
        tick(1);
        chk("dual_lane0", 32'(val_lane), 32'h0);
        pulse_done(1'b1);
        chk("dual_open2", 32'(locked), 32'hC);
        push = 4'b0011;
        tick(1);
        push = 4'b0000;
        exp_cnt = exp_cnt + 16'd2;
        chk("dual_locked", 32'(locked), 32'hF);
        chk("dual_cnt", 32'(pass_cnt), 32'(exp_cnt));

        // Reset during an outstanding request (pointer 1: grant 3)
        drop_coin(4'b1000);
        chk("mid_req", 32'(val_req), 32'h1);
        chk("mid_lane", 32'(val_lane), 32'h3);
        #1;
        rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        chk("mid_req_drop", 32'(val_req), 32'h0);
        chk("mid_lane_clr", 32'(val_lane), 32'h0);
        chk("mid_cnt_clr", 32'(pass_cnt), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        pulse_done(1'b1);
        chk("late_locked", 32'(locked), 32'hF);
        chk("late_reject", 32'(reject), 32'h0);
        chk("late_req", 32'(val_req), 32'h0);
        tick(1);
        chk("late_locked2", 32'(locked), 32'hF);
        chk("late_reject2", 32'(reject), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turnstile_bank_controller.md
# turnstile_bank_controller

Sequences a bank of turnstile lanes that share one coin validator. Each lane runs its own lock state machine. A round-robin arbiter grants the single validator to lanes with pending coins. The block sits between the per-lane coin/push sensors and the shared validator, drives every lane's lock output, and keeps a running passage count for the bank.

## Interface
- NUM_LANES, 4, number of turnstile lanes (≥2)
- TIMEOUT_CYCLES, 1000, cycles a lane stays unlocked without a push before relocking (≥1)
- COUNT_WIDTH, 16, width of the passage counter
- LANE_W (localparam), $clog2(NUM_LANES), lane index width

Ports:
- i_Clk  in  1  clock; all logic on rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Coin  in  NUM_LANES  per-lane coin-inserted level; a rising edge is one coin
- i_Push  in  NUM_LANES  per-lane push sensor level
- o_Val_Req  out  1  validation request to the shared validator
- o_Val_Lane  out  LANE_W  lane whose coin is being validated
- i_Val_Done  in  1  validator finished (1-cycle pulse)
- i_Val_Ok  in  1  coin valid; qualified by i_Val_Done
- o_Locked  out  NUM_LANES  1 = lane locked
- o_Reject  out  NUM_LANES  1-cycle pulse: lane's coin rejected
- o_Pass_Count  out  COUNT_WIDTH  total passages since reset

## Operation
- Coin edge detect: a registered copy of i_Coin resets to 0. edge = i_Coin & ~prev. A coin held high through reset release counts as one coin.
- Lane FSM has three states: LOCKED, PENDING and UNLOCKED. o_Locked = (state != UNLOCKED).
  - LOCKED -> PENDING on a coin edge.
  - PENDING -> UNLOCKED on i_Val_Done & i_Val_Ok for this lane.
  - PENDING -> LOCKED on i_Val_Done & ~i_Val_Ok for this lane, with an o_Reject pulse.
  - UNLOCKED -> LOCKED on i_Push. o_Pass_Count increments at the same time.
  - UNLOCKED -> LOCKED on timeout. No count.
  - Coin edges in PENDING or UNLOCKED are ignored; the coin is returned mechanically, and no state changes.
  - i_Push in LOCKED or PENDING has no effect.
- Timeout counter per lane:
  - Loads 0 on entry to UNLOCKED and increments each cycle in UNLOCKED.
  - Expires when count == TIMEOUT_CYCLES-1.
  - If push and expiry coincide, push wins and is counted.
- Arbiter FSM has two states: IDLE and BUSY.
  - IDLE: if any lane is PENDING, grant the first PENDING lane at or after the rotating pointer. Register o_Val_Lane, set o_Val_Req=1 and go to BUSY.
  - BUSY: hold o_Val_Req and o_Val_Lane stable until i_Val_Done is sampled. Then clear o_Val_Req, set pointer = granted lane + 1 (mod NUM_LANES) and return to IDLE.
  - The arbiter always spends at least one cycle in IDLE between grants.
  - i_Val_Done while in IDLE is ignored, and i_Val_Ok is ignored.
- o_Pass_Count wraps modulo 2^COUNT_WIDTH. Multiple lanes pushing in the same cycle add their combined count in that cycle.
- Reset (async, any time): all lanes LOCKED, o_Locked all 1, o_Val_Req 0, o_Val_Lane 0, pointer 0, o_Reject 0, o_Pass_Count 0, timeouts 0. An in-flight validation is abandoned, and a late i_Val_Done is ignored because the arbiter is in IDLE.

## Timing
- Coin edge sampled at clock edge t: the lane is PENDING after t+1.
- If the arbiter is IDLE, o_Val_Req is high after t+2.
- i_Val_Done sampled at edge d:
  - o_Locked low or o_Reject high after d+1, and o_Val_Req low after d+1.
  - The next grant is visible after d+2 at the earliest.
- Push sampled at edge p: o_Locked high and o_Pass_Count updated after p+1.
- Timeout: o_Locked is low for exactly TIMEOUT_CYCLES cycles when no push arrives.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset/idle: hold i_Reset_n=0 with random inputs. Required: o_Locked=4'b1111, o_Val_Req=0, o_Pass_Count=0. Release reset with inputs at 0. Required: outputs unchanged for 20 cycles.
- Accept and pass (NUM_LANES=4, TIMEOUT_CYCLES=8): coin on lane 2. Required: o_Val_Req=1 and o_Val_Lane=2 two cycles later. Pulse Done with Ok=1. Required: o_Locked=4'b1011. Push lane 2. Required: o_Locked=4'b1111 and o_Pass_Count=1.
- Reject: coin on lane 1, then Done with Ok=0. Required: o_Reject=4'b0010 for one cycle, lane 1 stays locked, count unchanged.
- Round robin: coins on lanes 0, 1 and 3 in the same cycle. Required: grants in order 0, 1, 3. After lane 3 is served, a new coin on lane 0 together with a coin on lane 1 gives grants 0, then 1.
- Timeout and collision:
  - Unlock lane 0 with no push. Required: it relocks after exactly 8 unlocked cycles, count unchanged.
  - Repeat with the push on the expiry cycle. Required: count increments.
  - Coin edge while lane 0 is UNLOCKED. Required: no new request.
- Mid-operation reset: assert i_I_Reset_n low while o_Val_Req=1. Required: o_Val_Req drops immediately. A Done pulse after release causes no unlock and no reject.
